// File: rtl/cpu_intr_ctrl.sv
// rtl/cpu_intr_ctrl.sv - prioritised vectored interrupt controller, nesting via CPU_INTR_NEST_EN
module cpu_intr_ctrl #(
    parameter int N_SRC = 4,
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] VEC_BASE = 'h100,
    parameter logic [XLEN-1:0] VEC_STRIDE = 'h10,
    parameter int NEST_DEPTH = 4,
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             gie_we,
    input  logic             gie_wdata,
    input  logic             vec_we,
    input  logic [SEL_W-1:0] vec_sel,
    input  logic [XLEN-1:0]  vec_wdata,
    input  logic             commit,
    input  logic [XLEN-1:0]  pc,
    input  logic             iret,
    output logic             intr_take,
    output logic [XLEN-1:0]  intr_target,
    output logic [XLEN-1:0]  intr_pc,
    output logic             intr_en,
    output logic             in_isr,
    output logic [N_SRC-1:0] pending
);

`ifdef CPU_INTR_NEST_EN
    localparam bit NEST_EN = 1'b1;
`else
    localparam bit NEST_EN = 1'b0;
`endif

    localparam int DW = $clog2(NEST_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(NEST_DEPTH);
    localparam logic [SEL_W:0] N_SRC_W = (SEL_W + 1)'(N_SRC);

    typedef enum logic {
        IDLE = 1'b0,
        ISR  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  irq_q, mask_q, pending_q, eligible, irq_rise, take_mask;
    logic [XLEN-1:0]   vec_q [N_SRC];
    logic [XLEN-1:0]   pc_q;
    logic [SEL_W-1:0]  cur_id_q, sel_id;
    logic              en_q, any_elig, iret_isr, push, pop;

    // save stack of preempted {return pc, source id}; contents need no reset
    logic [XLEN-1:0]   stk_pc [NEST_DEPTH];
    logic [SEL_W-1:0]  stk_id [NEST_DEPTH];
    logic [DW-1:0]     depth_q, top_idx;

    assign irq_rise    = irq & ~irq_q;
    assign eligible    = pending_q & mask_q;
    assign any_elig    = |eligible;
    assign top_idx     = depth_q - DW'(1);
    assign intr_target = vec_q[sel_id];
    assign intr_pc     = pc_q;
    assign intr_en     = en_q;
    assign in_isr      = (state_q == ISR);
    assign pending     = pending_q;

    // lowest eligible index wins
    always_comb begin
        sel_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) sel_id = SEL_W'(i);
        end
    end

    // next state, take decision, stack push/pop; iret blocks a same-cycle take
    always_comb begin
        state_d   = state_q;
        intr_take = 1'b0;
        iret_isr  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit && en_q && any_elig) begin
                    intr_take = 1'b1;
                    state_d   = ISR;
                end
            end
            ISR: begin
                if (iret) begin
                    iret_isr = 1'b1;
                    if (NEST_EN && (depth_q != '0)) pop = 1'b1;
                    else state_d = IDLE;
                end else if (NEST_EN && commit && any_elig && (sel_id < cur_id_q) &&
                             (depth_q < DEPTH_MAX)) begin
                    intr_take = 1'b1;
                    push      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d   = IDLE;
            intr_take = 1'b0;
            iret_isr  = 1'b0;
            push      = 1'b0;
            pop       = 1'b0;
        end
    end

    // one-hot of the source being serviced this cycle
    always_comb begin
        take_mask = '0;
        if (intr_take) take_mask[sel_id] = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // request latching, configuration registers and saved context
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            en_q      <= 1'b0;
            pc_q      <= '0;
            cur_id_q  <= '0;
            depth_q   <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                vec_q[i] <= VEC_BASE + XLEN'(i) * VEC_STRIDE;
            end
        end else begin
            irq_q     <= irq;
            pending_q <= (pending_q & ~take_mask) | irq_rise;
            if (mask_we) mask_q <= mask_wdata;
            if (vec_we && ({1'b0, vec_sel} < N_SRC_W)) vec_q[vec_sel] <= vec_wdata;
            if (gie_we) en_q <= gie_wdata;
            if (iret_isr && !pop) en_q <= 1'b1;
            if (intr_take) en_q <= 1'b0;
            if (intr_take) begin
                pc_q     <= pc;
                cur_id_q <= sel_id;
            end else if (pop) begin
                pc_q     <= stk_pc[top_idx];
                cur_id_q <= stk_id[top_idx];
            end
            if (push)     depth_q <= depth_q + DW'(1);
            else if (pop) depth_q <= top_idx;
        end
    end

    // stack storage written on preemption
    always_ff @(posedge clk) begin
        if (push) begin
            stk_pc[depth_q] <= pc_q;
            stk_id[depth_q] <= cur_id_q;
        end
    end

endmodule

// File: tb/tb_cpu_intr_ctrl.sv
// tb/tb_cpu_intr_ctrl.sv - directed self-checking bench for cpu_intr_ctrl
module tb_cpu_intr_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        gie_we;
    logic        gie_wdata;
    logic        vec_we;
    logic [1:0]  vec_sel;
    logic [31:0] vec_wdata;
    logic        commit;
    logic [31:0] pc;
    logic        iret;
    logic        intr_take;
    logic [31:0] intr_target;
    logic [31:0] intr_pc;
    logic        intr_en;
    logic        in_isr;
    logic [3:0]  pending;

    int checks = 0;
    int failures = 0;

    cpu_intr_ctrl #(
        .N_SRC(4), .XLEN(32), .VEC_BASE(32'h100), .VEC_STRIDE(32'h10), .NEST_DEPTH(1)
    ) dut (
        .clk(clk), .rst(rst), .irq(irq),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .gie_we(gie_we), .gie_wdata(gie_wdata),
        .vec_we(vec_we), .vec_sel(vec_sel), .vec_wdata(vec_wdata),
        .commit(commit), .pc(pc), .iret(iret),
        .intr_take(intr_take), .intr_target(intr_target), .intr_pc(intr_pc),
        .intr_en(intr_en), .in_isr(in_isr), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; irq = '0; mask_we = 0; mask_wdata = '0; gie_we = 0; gie_wdata = 0;
        vec_we = 0; vec_sel = '0; vec_wdata = '0; commit = 0; pc = '0; iret = 0;
        @(negedge clk);
        tick(); tick();
        commit = 1; #1;
        chk("rst_take", intr_take, 1'b0);
        chk("rst_in_isr", in_isr, 1'b0);
        chk("rst_intr_en", intr_en, 1'b0);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_intr_pc", intr_pc, 32'h0);
        commit = 0; rst = 0;
        tick();

        // single source take
        gie_we = 1; gie_wdata = 1; mask_we = 1; mask_wdata = 4'b0010;
        tick();
        gie_we = 0; mask_we = 0; irq = 4'b0010;
        tick();
        chk("t1_pending", pending, 4'b0010);
        commit = 1; pc = 32'h40; #1;
        chk("t1_take", intr_take, 1'b1);
        chk("t1_target", intr_target, 32'h110);
        tick();
        commit = 0; #1;
        chk("t1_intr_pc", intr_pc, 32'h40);
        chk("t1_intr_en", intr_en, 1'b0);
        chk("t1_in_isr", in_isr, 1'b1);
        chk("t1_pending_clr", pending, 4'b0000);
        iret = 1; commit = 1; #1;
        chk("t1_iret_no_take", intr_take, 1'b0);
        tick();
        iret = 0; commit = 0; #1;
        chk("t1_iret_idle", in_isr, 1'b0);
        chk("t1_iret_en", intr_en, 1'b1);
        chk("t1_iret_pc_kept", intr_pc, 32'h40);
        irq = '0;
        tick();

        // priority between simultaneous sources
        mask_we = 1; mask_wdata = 4'hF;
        tick();
        mask_we = 0; irq = 4'b1001;
        tick();
        chk("t2_pending", pending, 4'b1001);
        commit = 1; pc = 32'h80; #1;
        chk("t2_take", intr_take, 1'b1);
        chk("t2_target", intr_target, 32'h100);
        tick();
        #1;
        chk("t2_pending_left", pending, 4'b1000);
        chk("t2_no_take_in_isr", intr_take, 1'b0);
        iret = 1; #1;
        chk("t2_iret_cycle_no_take", intr_take, 1'b0);
        tick();
        iret = 0; pc = 32'h90; #1;
        chk("t2_next_take", intr_take, 1'b1);
        chk("t2_next_target", intr_target, 32'h130);
        tick();
        commit = 0; #1;
        chk("t2_pending_empty", pending, 4'b0000);
        chk("t2_intr_pc", intr_pc, 32'h90);
        iret = 1; commit = 1;
        tick();
        iret = 0; commit = 0; irq = '0;
        tick();

        // vector write in the take cycle, plus gie write losing to the take
        irq = 4'b0100;
        tick();
        vec_we = 1; vec_sel = 2'd2; vec_wdata = 32'h800; commit = 1; pc = 32'hA0; #1;
        chk("t3_take", intr_take, 1'b1);
        chk("t3_target_old", intr_target, 32'h120);
        tick();
        vec_we = 0; commit = 0; iret = 1; commit = 1;
        tick();
        iret = 0; commit = 0; irq = '0;
        tick();
        irq = 4'b0100;
        tick();
        commit = 1; gie_we = 1; gie_wdata = 1; #1;
        chk("t3_target_new", intr_target, 32'h800);
        tick();
        commit = 0; gie_we = 0; #1;
        chk("t3_gie_loses", intr_en, 1'b0);
        iret = 1; commit = 1;
        tick();
        iret = 0; commit = 0; irq = '0;
        tick();

        // global enable off, then mask off
        gie_we = 1; gie_wdata = 0;
        tick();
        gie_we = 0; irq = 4'b0001;
        tick();
        commit = 1; #1;
        chk("t4_gie_off_no_take", intr_take, 1'b0);
        tick();
        commit = 0; #1;
        chk("t4_pending_latched", pending, 4'b0001);
        gie_we = 1; gie_wdata = 1;
        tick();
        gie_we = 0; commit = 1; #1;
        chk("t4_take_after_gie", intr_target, 32'h100);
        chk("t4_take_after_gie_v", intr_take, 1'b1);
        tick();
        commit = 0; iret = 1; commit = 1;
        tick();
        iret = 0; commit = 0; irq = '0; mask_we = 1; mask_wdata = '0;
        tick();
        mask_we = 0; irq = 4'b0001;
        tick();
        commit = 1; #1;
        chk("t4_mask_off_no_take", intr_take, 1'b0);
        chk("t4_mask_off_pending", pending, 4'b0001);
        commit = 0; irq = '0;
        tick();

        // reset in the middle of an ISR with irq held high
        rst = 1;
        tick();
        rst = 0; mask_we = 1; mask_wdata = 4'b0010; gie_we = 1; gie_wdata = 1;
        tick();
        mask_we = 0; gie_we = 0; irq = 4'b0010;
        tick();
        commit = 1; pc = 32'h44; #1;
        chk("t5_pre_take", intr_take, 1'b1);
        tick();
        commit = 0; #1;
        chk("t5_in_isr", in_isr, 1'b1);
        rst = 1; commit = 1; #1;
        chk("t5_no_take_in_rst", intr_take, 1'b0);
        tick();
        rst = 0; commit = 0;
        tick();
        chk("t5_in_isr_cleared", in_isr, 1'b0);
        chk("t5_en_cleared", intr_en, 1'b0);
        chk("t5_pending_edge", pending, 4'b0010);
        chk("t5_pc_cleared", intr_pc, 32'h0);
        commit = 1; #1;
        chk("t5_no_take_unarmed", intr_take, 1'b0);
        commit = 0; mask_we = 1; mask_wdata = 4'b0010;
        tick();
        mask_we = 0; commit = 1; #1;
        chk("t5_no_take_mask_only", intr_take, 1'b0);
        commit = 0; gie_we = 1; gie_wdata = 1;
        tick();
        gie_we = 0; commit = 1; pc = 32'h48; #1;
        chk("t5_take_armed", intr_take, 1'b1);
        chk("t5_target", intr_target, 32'h110);
        tick();
        commit = 0; iret = 1; commit = 1;
        tick();
        iret = 0; commit = 0; irq = '0;
        tick();

`ifdef CPU_INTR_NEST_EN
        // preemption with a one-entry save stack
        mask_we = 1; mask_wdata = 4'hF;
        tick();
        mask_we = 0; irq = 4'b0100;
        tick();
        commit = 1; pc = 32'h40;
        tick();
        commit = 0; irq = 4'b0101;
        tick();
        commit = 1; pc = 32'h200; #1;
        chk("n_preempt_take", intr_take, 1'b1);
        chk("n_preempt_target", intr_target, 32'h100);
        tick();
        commit = 0; irq = 4'b0111; #1;
        chk("n_preempt_pc", intr_pc, 32'h200);
        tick();
        commit = 1; #1;
        chk("n_full_no_take", intr_take, 1'b0);
        tick();
        commit = 0; #1;
        chk("n_full_pending", pending, 4'b0010);
        iret = 1; commit = 1; #1;
        chk("n_pop_no_take", intr_take, 1'b0);
        tick();
        #1;
        chk("n_pop_pc", intr_pc, 32'h40);
        chk("n_pop_in_isr", in_isr, 1'b1);
        tick();
        iret = 0; commit = 0; #1;
        chk("n_final_idle", in_isr, 1'b0);
        chk("n_final_en", intr_en, 1'b1);
        commit = 1; #1;
        chk("n_after_target", intr_target, 32'h110);
        tick();
        commit = 0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_intr_ctrl.md
CPU_INTR_CTRL -- requirements
Module: cpu_intr_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of interrupt sources, 1..8; index 0 is the highest priority.
REQ-002 SHALL have parameter XLEN, default 32: width of the PC and vector fields.
REQ-003 SHALL have parameter VEC_BASE, default 32'h100: reset vector of source 0.
REQ-004 SHALL have parameter VEC_STRIDE, default 32'h10: reset vector spacing; vec[i] = VEC_BASE + i*VEC_STRIDE.
REQ-005 SHALL have parameter NEST_DEPTH, default 4: save-stack depth, used only when CPU_INTR_NEST_EN is defined.
REQ-006 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 Port rst  in  1  reset, synchronous, active-high.
REQ-008 Port irq  in  N_SRC  level interrupt request lines, synchronous to clk.
REQ-009 Port mask_we / mask_wdata  in  1 / N_SRC  write of the per-source enable mask.
REQ-010 Port gie_we / gie_wdata  in  1 / 1  software write of the global enable intr_en.
REQ-011 Port vec_we / vec_sel / vec_wdata  in  1 / $clog2(N_SRC) (min 1) / XLEN  write of vector vec_sel.
REQ-012 Port commit  in  1  instruction boundary; an interrupt may be taken only in a commit cycle.
REQ-013 Port pc  in  XLEN  return address of the committing instruction; valid when commit=1.
REQ-014 Port iret  in  1  return-from-interrupt commits this cycle.
REQ-015 Port intr_take  out  1  combinational pulse: redirect fetch to intr_target this cycle.
REQ-016 Port intr_target / intr_pc  out  XLEN / XLEN  selected vector / saved return PC (top of save state).
REQ-017 Port intr_en / in_isr / pending  out  1 / 1 / N_SRC  global enable, servicing flag, latched requests.

Function
REQ-018 pending[i] SHALL set on a rising edge of irq[i], i.e. irq[i]=1 while registered irq_q[i]=0.
REQ-019 pending[i] SHALL clear only when source i is taken. If a new edge and a take of the same source occur in the same cycle, the set wins.
REQ-020 eligible = pending & mask. Selected id = lowest set index of eligible.
REQ-021 intr_take SHALL equal commit & intr_en & (eligible != 0) in IDLE. intr_target = vec[id]. Zero added latency.
REQ-022 On the clock edge of a take, the block SHALL:
  - set intr_pc <= pc and cur_id <= id;
  - clear pending[id];
  - set intr_en <= 0;
  - move the FSM IDLE -> ISR.
REQ-023 FSM states: IDLE and ISR. in_isr=1 exactly in ISR.
REQ-024 iret in ISR SHALL set intr_en <= 1 and move to IDLE. iret in IDLE SHALL be ignored. intr_pc is unchanged by iret.
REQ-025 The earliest next take after an iret SHALL be the following commit cycle, not the iret cycle itself.
REQ-026 A take SHALL use the pre-edge mask, vec and intr_en values; a same-cycle mask_we, vec_we or gie_we takes effect on the next cycle.
REQ-027 If a take and gie_we occur in the same cycle, the take's intr_en <= 0 SHALL win.
REQ-028 With mask=0 or intr_en=0, the block SHALL never assert intr_take, while pending continues to latch.
REQ-029 vec_sel >= N_SRC SHALL be ignored.

Reset
REQ-030 rst=1 SHALL force the following on the next edge, regardless of mid-ISR state:
  - pending=0, irq_q=0, mask=0, intr_en=0;
  - intr_pc=0, cur_id=0, FSM=IDLE;
  - vec[i]=VEC_BASE+i*VEC_STRIDE;
  - save stack emptied.
REQ-031 Because irq_q resets to 0, an irq line held high through reset release SHALL register an edge on the first cycle after reset.
REQ-032 intr_take SHALL be 0 while rst=1.

Configuration
REQ-033 Macro CPU_INTR_NEST_EN.
  - Undefined: behaviour is exactly REQ-018..REQ-029; no preemption.
  - Defined: in ISR, a commit with an eligible id < cur_id and stack depth < NEST_DEPTH SHALL take as in REQ-021/022, and SHALL push {intr_pc, cur_id} to the stack. intr_en is ignored for this preemption check.
  - Defined: iret with a non-empty stack SHALL pop into {intr_pc, cur_id} and remain in ISR. iret with an empty stack SHALL behave per REQ-024.
  - Defined: when the stack is full, preemption SHALL be suppressed and the request SHALL stay pending.

Verification
REQ-034 Reset, gie=1, mask=4'b0010, irq[1] rises, commit with pc=0x40 -> intr_take=1 and intr_target=0x110 that cycle; next cycle intr_pc=0x40, intr_en=0, in_isr=1, pending=0.
REQ-035 irq[3] and irq[0] rise together, mask=4'hF, commit -> id 0 taken (target 0x100), pending=4'b1000. After iret, the next commit takes id 3 (target 0x130).
REQ-036 vec_we sel=2 data=0x800 in the same cycle as a take of source 2 -> target 0x120. A later take of source 2 -> target 0x800.
REQ-037 irq[1] held high, rst pulsed while in ISR -> after release in_isr=0, intr_en=0, pending=4'b0010. No take occurs until mask and gie are set.
REQ-038 CPU_INTR_NEST_EN with NEST_DEPTH=1:
  - in ISR for source 2, take source 0 at pc=0x200 -> stack holds {0x40, 2};
  - source 1 then rises -> no take (stack full, and id 1 > cur_id 0);
  - first iret -> intr_pc=0x40, cur_id=2, still in ISR;
  - second iret -> IDLE.
